qspi_ram_reader: RTL and testbench
==================================

QSPI_RAM_READER -- requirements
Module: qspi_ram_reader

Interface
REQ-001 Parameter DUMMY_CYCLES, default 6, meaning the number of SPI clocks with the bus released between address and data.
REQ-002 Parameter READ_CMD, default 8'hEB, meaning the quad-read command byte.
REQ-003 clock  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_req  in  1  burst request, sampled when out_busy=0.
REQ-006 in_addr  in  24  byte address of the first byte.
REQ-007 in_bank  in  2  RAM bank select.
REQ-008 in_count  in  8  bytes to read; 0 means 256.
REQ-009 out_busy  out  1  burst in progress.
REQ-010 out_data  out  8  read byte.
REQ-011 out_valid  out  1  out_data valid, one-cycle pulse per byte.
REQ-012 out_done  out  1  one-cycle pulse at burst end.
REQ-013 out_ram_csn  out  1  RAM chip select, active low.
REQ-014 out_ram_clk  out  1  RAM SPI clock.
REQ-015 out_ram_bank  out  2  latched bank select.
REQ-016 ram_io_i  in  4  io3..io0 input path.
REQ-017 ram_io_o  out  4  io3..io0 output path.
REQ-018 ram_io_oe  out  4  io3..io0 output enables, active high.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 States SHALL be IDLE, CMD (2 nibbles), ADDR (6 nibbles), DUMMY (DUMMY_CYCLES clocks), DATA (2 nibbles per byte), END.
REQ-021 In cycle 0, in_req=1 and out_busy=0 SHALL be accepted, latching in_addr, in_bank and in_count, and moving the FSM from IDLE to CMD.
REQ-022 Cycle timing, nibble k (k=0,1,...):
- out_ram_csn=0 and out_busy=1 from cycle 1.
- Each SPI clock SHALL span two system cycles: nibble k is driven on ram_io_o in cycles 1+2k and 2+2k.
- out_ram_clk=0 in cycle 1+2k and 1 in cycle 2+2k.
REQ-023 Nibble order SHALL be MSB-nibble first: READ_CMD[7:4], READ_CMD[3:0], then address bits [23:20] down to [3:0].
REQ-024 ram_io_oe SHALL be 4'hF during CMD and ADDR, and 4'h0 during DUMMY, DATA and END.
REQ-025 In DATA, ram_io_i SHALL be sampled at the clock edge ending each ram_clk-high cycle; the high nibble is sampled first.
REQ-026 Byte n (n=0..N-1) SHALL appear with out_valid=1 in cycle 21+2*DUMMY_CYCLES+4n, which is cycle 33+4n at default.
REQ-027 The bus SHALL be released in the cycle after the last nibble is sampled: out_ram_csn=1, out_ram_clk=0, FSM to END; this is the same cycle as the final out_valid.
REQ-028 out_done SHALL pulse in the cycle after the final out_valid, with out_busy=0 in that same cycle.
REQ-029 A new in_req SHALL be accepted in the out_done cycle, which guarantees csn high for at least 2 cycles.
REQ-030 in_req while out_busy=1 SHALL be ignored, with no queueing.
REQ-031 The byte counter SHALL be 9 bits so that in_count=0 yields exactly 256 bytes.
REQ-032 Address wrap is the RAM's responsibility; this block SHALL never re-issue the address.
REQ-033 out_ram_bank SHALL hold the latched bank from cycle 1 until the next accepted request.
REQ-034 out_data SHALL hold its last value when out_valid=0.

Reset
REQ-035 While reset=1, the block SHALL immediately (asynchronously) assert: FSM=IDLE, out_ram_csn=1, out_ram_clk=0, ram_io_oe=4'h0, ram_io_o=4'h0, out_ram_bank=2'b00, out_data=8'h00, and out_busy, out_valid and out_done all 0.
REQ-036 Reset asserted mid-burst SHALL abort the burst with no out_done, and no out_valid or out_done SHALL appear after reset is released.
REQ-037 The first request after reset release SHALL be accepted on the first rising edge with reset=0.

Verification
REQ-038 Bench SHALL cover single byte: in_addr=24'h123456, in_count=1, RAM model returns 8'hA5 -> nibbles E,B,1,2,3,4,5,6 on io with oe=F; oe=0 for 6 clocks; out_valid with 8'hA5 at cycle 33; out_done at cycle 34.
REQ-039 Bench SHALL cover a 4-byte burst, model bytes 01,02,03,04 -> out_valid at cycles 33,37,41,45 with the matching data; exactly 4 pulses.
REQ-040 Bench SHALL cover in_count=0 -> exactly 256 out_valid pulses, then one out_done.
REQ-041 Bench SHALL cover in_req held high throughout a burst -> the second burst starts with csn low in the cycle after out_done; csn is high for at least 2 cycles between bursts.
REQ-042 Bench SHALL cover reset asserted during DUMMY -> csn=1 and oe=0 within the same cycle; no out_done; a new request after release completes normally.
REQ-043 Bench SHALL cover in_bank=2'b10 with DUMMY_CYCLES=4 -> out_ram_bank=2'b10 from cycle 1, and first out_valid at cycle 29.

Source files
------------

// File: rtl/qspi_ram_reader.sv
// Quad-SPI RAM burst reader. Sends command and address, idles the bus for dummy
// clocks, then shifts in bytes high nibble first. Every output is registered.
module qspi_ram_reader #(
  parameter int unsigned DUMMY_CYCLES = 6,
  parameter logic [7:0]  READ_CMD     = 8'hEB
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_req,
  input  logic [23:0] in_addr,
  input  logic [1:0]  in_bank,
  input  logic [7:0]  in_count,
  output logic        out_busy,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_done,
  output logic        out_ram_csn,
  output logic        out_ram_clk,
  output logic [1:0]  out_ram_bank,
  input  logic [3:0]  ram_io_i,
  output logic [3:0]  ram_io_o,
  output logic [3:0]  ram_io_oe
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, END} state_t;

  localparam logic [7:0] DummyLast = 8'(DUMMY_CYCLES - 1);

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [27:0] shift_q, shift_d;
  logic [8:0]  bytes_q, bytes_d;
  logic [3:0]  hinib_q, hinib_d;
  logic        csn_q, csn_d;
  logic        sclk_q, sclk_d;
  logic [3:0]  io_q, io_d;
  logic [3:0]  oe_q, oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [1:0]  bank_q, bank_d;

  // phase_q=0 is the ram_clk-low half of an SPI clock, phase_q=1 the high half;
  // outputs are computed one cycle ahead so they can all come straight from flops.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bytes_d = bytes_q;
    hinib_d = hinib_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    io_d    = io_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (in_req && !busy_q) begin
          state_d = CMD;
          phase_d = 1'b0;
          cnt_d   = 8'd0;
          shift_d = {READ_CMD[3:0], in_addr};
          bytes_d = (in_count == 8'd0) ? 9'd256 : {1'b0, in_count};
          bank_d  = in_bank;
          csn_d   = 1'b0;
          sclk_d  = 1'b0;
          io_d    = READ_CMD[7:4];
          oe_d    = 4'hF;
          busy_d  = 1'b1;
        end
      end
      CMD, ADDR: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          shift_d = {shift_q[23:0], 4'h0};
          io_d    = shift_q[27:24];
          cnt_d   = cnt_q + 8'd1;
          if (state_q == CMD && cnt_q == 8'd1) begin
            state_d = ADDR;
            cnt_d   = 8'd0;
          end else if (state_q == ADDR && cnt_q == 8'd5) begin
            state_d = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
            cnt_d   = 8'd0;
            io_d    = 4'h0;
            oe_d    = 4'h0;
          end
        end
      end
      DUMMY: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == DummyLast) begin
            state_d = DATA;
            cnt_d   = 8'd0;
          end
        end
      end
      DATA: begin
        // Sampling happens on the edge that closes the ram_clk-high cycle.
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else if (!cnt_q[0]) begin
          hinib_d = ram_io_i;
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = 8'd1;
        end else begin
          data_d  = {hinib_q, ram_io_i};
          valid_d = 1'b1;
          bytes_d = bytes_q - 9'd1;
          cnt_d   = 8'd0;
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          if (bytes_q == 9'd1) begin
            state_d = END;
            csn_d   = 1'b1;
          end
        end
      end
      END: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q   <= 8'd0;
      shift_q <= 28'd0;
      bytes_q <= 9'd0;
      hinib_q <= 4'h0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      io_q    <= 4'h0;
      oe_q    <= 4'h0;
      busy_q  <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      bank_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bytes_q <= bytes_d;
      hinib_q <= hinib_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      bank_q  <= bank_d;
    end
  end

  assign out_busy     = busy_q;
  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign out_done     = done_q;
  assign out_ram_csn  = csn_q;
  assign out_ram_clk  = sclk_q;
  assign out_ram_bank = bank_q;
  assign ram_io_o     = io_q;
  assign ram_io_oe    = oe_q;

endmodule

// File: tb/tb_qspi_ram_reader.sv
// Directed bench for qspi_ram_reader: two instances (6 and 4 dummy clocks), each
// served by a behavioural quad-SPI RAM that returns bytes from a shared array.
module tb_qspi_ram_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [23:0] addr = 24'h0;
  logic [1:0]  bank = 2'b00;
  logic [7:0]  count = 8'h0;

  logic       busy0, valid0, done0, csn0, rclk0;
  logic [7:0] data0;
  logic [1:0] rbank0;
  logic [3:0] ioI0, ioO0, ioOe0;
  logic       busy1, valid1, done1, csn1, rclk1;
  logic [7:0] data1;
  logic [1:0] rbank1;
  logic [3:0] ioI1, ioO1, ioOe1;

  logic [7:0] mem [256];
  int sclk0 = 0, sclk1 = 0;
  int j0, j1;
  int checks = 0, errors = 0;
  logic [7:0] lastData [2];
  logic sel = 1'b0;

  logic       sCsn, sClk, sBusy, sValid, sDone;
  logic [7:0] sData;
  logic [1:0] sBank;
  logic [3:0] sIo, sOe;

  always #5 clock = ~clock;

  qspi_ram_reader #(.DUMMY_CYCLES(6), .READ_CMD(8'hEB)) u0 (
    .clock(clock), .reset(reset), .in_req(req0), .in_addr(addr), .in_bank(bank),
    .in_count(count), .out_busy(busy0), .out_data(data0), .out_valid(valid0),
    .out_done(done0), .out_ram_csn(csn0), .out_ram_clk(rclk0), .out_ram_bank(rbank0),
    .ram_io_i(ioI0), .ram_io_o(ioO0), .ram_io_oe(ioOe0));

  qspi_ram_reader #(.DUMMY_CYCLES(4), .READ_CMD(8'hEB)) u1 (
    .clock(clock), .reset(reset), .in_req(req1), .in_addr(addr), .in_bank(bank),
    .in_count(count), .out_busy(busy1), .out_data(data1), .out_valid(valid1),
    .out_done(done1), .out_ram_csn(csn1), .out_ram_clk(rclk1), .out_ram_bank(rbank1),
    .ram_io_i(ioI1), .ram_io_o(ioO1), .ram_io_oe(ioOe1));

  // RAM models count SPI clocks since chip select fell and present data nibble
  // j = clocks - 9 - dummy while that clock is high, high nibble first.
  always @(posedge rclk0 or posedge csn0)
    if (csn0) sclk0 <= 0; else sclk0 <= sclk0 + 1;
  always @(posedge rclk1 or posedge csn1)
    if (csn1) sclk1 <= 0; else sclk1 <= sclk1 + 1;

  always_comb begin
    j0 = sclk0 - 15;
    ioI0 = 4'h0;
    if (!csn0 && j0 >= 0) ioI0 = j0[0] ? mem[j0[8:1]][3:0] : mem[j0[8:1]][7:4];
  end

  always_comb begin
    j1 = sclk1 - 13;
    ioI1 = 4'h0;
    if (!csn1 && j1 >= 0) ioI1 = j1[0] ? mem[j1[8:1]][3:0] : mem[j1[8:1]][7:4];
  end

  always_comb begin
    sCsn   = sel ? csn1   : csn0;
    sClk   = sel ? rclk1  : rclk0;
    sBusy  = sel ? busy1  : busy0;
    sValid = sel ? valid1 : valid0;
    sDone  = sel ? done1  : done0;
    sData  = sel ? data1  : data0;
    sBank  = sel ? rbank1 : rbank0;
    sIo    = sel ? ioO1   : ioO0;
    sOe    = sel ? ioOe1  : ioOe0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a burst from mid-cycle (cycle 0) and checks every cycle through out_done.
  task automatic applyStimulus(input int inst, input logic [23:0] a, input logic [7:0] cnt,
                               input logic [1:0] b, input bit hold, input int dummy);
    int n, first, last, validSeen, doneSeen, k;
    logic [31:0] nibs;
    logic validExp;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    first = 21 + 2 * dummy;
    last = first + 4 * (n - 1);
    validSeen = 0;
    doneSeen = 0;
    nibs = {8'hEB, a};
    sel = (inst == 1);
    addr = a;
    count = cnt;
    bank = b;
    if (inst == 1) req1 = 1'b1; else req0 = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clock);
      #1;
      if (!hold) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clock);
      checkOutput($sformatf("csn@%0d", c), 32'(sCsn), 32'(c >= last));
      checkOutput($sformatf("busy@%0d", c), 32'(sBusy), 32'(c <= last));
      checkOutput($sformatf("done@%0d", c), 32'(sDone), 32'(c == last + 1));
      checkOutput($sformatf("bank@%0d", c), 32'(sBank), 32'(b));
      checkOutput($sformatf("rclk@%0d", c), 32'(sClk), 32'((c < last) && ((c - 1) % 2 == 1)));
      checkOutput($sformatf("oe@%0d", c), 32'(sOe), (c <= 16) ? 32'hF : 32'h0);
      if (c <= 16) begin
        k = (c - 1) / 2;
        checkOutput($sformatf("io@%0d", c), 32'(sIo), 32'(nibs[31 - 4 * k -: 4]));
      end
      validExp = (c >= first) && (c <= last) && ((c - first) % 4 == 0);
      if (validExp) lastData[inst] = mem[(c - first) / 4];
      checkOutput($sformatf("valid@%0d", c), 32'(sValid), 32'(validExp));
      checkOutput($sformatf("data@%0d", c), 32'(sData), 32'(lastData[inst]));
      if (sValid) validSeen++;
      if (sDone) doneSeen++;
    end
    checkOutput("validPulses", 32'(validSeen), 32'(n));
    checkOutput("donePulses", 32'(doneSeen), 32'd1);
  endtask

  initial begin
    int pulses;
    lastData[0] = 8'h00;
    lastData[1] = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    #1 reset = 1'b1;
    #1;
    checkOutput("rstCsn", 32'(csn0), 32'd1);
    checkOutput("rstClk", 32'(rclk0), 32'd0);
    checkOutput("rstOe", 32'(ioOe0), 32'h0);
    checkOutput("rstIo", 32'(ioO0), 32'h0);
    checkOutput("rstBusyValidDone", 32'({busy0, valid0, done0}), 32'h0);
    checkOutput("rstData", 32'(data0), 32'h0);
    checkOutput("rstBank", 32'(rbank0), 32'h0);
    checkOutput("rstCsn1", 32'(csn1), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] single byte burst");
    mem[0] = 8'hA5;
    applyStimulus(0, 24'h123456, 8'd1, 2'b00, 1'b0, 6);

    repeat (3) @(negedge clock);
    $display("[TB] four byte burst");
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    applyStimulus(0, 24'h000100, 8'd4, 2'b01, 1'b0, 6);

    repeat (3) @(negedge clock);
    $display("[TB] request held high across back-to-back bursts");
    mem[0] = 8'h3C; mem[1] = 8'hC3;
    applyStimulus(0, 24'hABCDEF, 8'd2, 2'b11, 1'b1, 6);
    applyStimulus(0, 24'h00FF00, 8'd1, 2'b10, 1'b0, 6);

    repeat (3) @(negedge clock);
    $display("[TB] 256 byte burst");
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    applyStimulus(0, 24'hFEDCBA, 8'd0, 2'b01, 1'b0, 6);

    repeat (3) @(negedge clock);
    $display("[TB] reset during dummy phase");
    sel = 1'b0;
    addr = 24'h555555;
    count = 8'd3;
    bank = 2'b11;
    req0 = 1'b1;
    @(posedge clock);
    #1 req0 = 1'b0;
    repeat (19) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checkOutput("abortCsn", 32'(csn0), 32'd1);
    checkOutput("abortOe", 32'(ioOe0), 32'h0);
    checkOutput("abortBusy", 32'(busy0), 32'd0);
    checkOutput("abortClk", 32'(rclk0), 32'd0);
    checkOutput("abortBank", 32'(rbank0), 32'd0);
    checkOutput("abortData", 32'(data0), 32'd0);
    lastData[0] = 8'h00;
    lastData[1] = 8'h00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (valid0 || done0 || !csn0) pulses++;
    end
    checkOutput("noActivityAfterAbort", 32'(pulses), 32'd0);
    mem[0] = 8'h96;
    applyStimulus(0, 24'h000010, 8'd1, 2'b00, 1'b0, 6);

    repeat (3) @(negedge clock);
    $display("[TB] bank 2 with four dummy clocks");
    mem[0] = 8'h5E; mem[1] = 8'hE5;
    applyStimulus(1, 24'h0A0B0C, 8'd2, 2'b10, 1'b0, 4);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
